debug_halt_controller: RTL and testbench
========================================

# debug_halt_controller

Sits between the debug peripheral and the CPU pipeline. Turns the debug halt request into a fetch stall and tracks instructions still in flight. Asserts `o_Pipeline_Flushed` once the pipeline and memory port are quiescent. While halted, converts the debug PC-write request into a single-cycle PC load pulse for the fetch stage.

## Interface
Parameters:
- `COUNT_BITS`, 3: width of the in-flight instruction counter. Saturates at 2^COUNT_BITS−1.
- `SETTLE_CYCLES`, 2: consecutive quiet cycles required before declaring the pipeline flushed. Must be ≥1.
- `TIMEOUT_CYCLES`, 1024: drain watchdog limit. Used only with `DEBUG_HALT_TIMEOUT_EN`.

Ports:
- `i_Clock` in 1: system clock.
- `i_Reset` in 1: reset, synchronous, active-high.
- `i_Halt_Request` in 1: level; from the debug peripheral's `o_Halt_Cpu`.
- `i_Issue` in 1: an instruction entered decode this cycle.
- `i_Retire` in 1: an instruction left writeback this cycle.
- `i_Squash` in 1: a pipeline flush killed instructions this cycle.
- `i_Squash_Count` in 2: number killed; valid only with `i_Squash`.
- `i_Mem_Busy` in 1: data-memory transaction outstanding.
- `i_Write_PC_Enable` in 1: level; from the debug peripheral.
- `i_Write_PC_Data` in 32: new PC.
- `o_Stall_Fetch` out 1: fetch must not issue.
- `o_Pipeline_Flushed` out 1: pipeline empty, debug access allowed.
- `o_PC_Load` out 1: one-cycle PC load strobe.
- `o_PC_Load_Data` out 32: PC value for the load.
- `o_Drain_Timeout` out 1: sticky watchdog flag. Tied to 0 when the feature is compiled out.

## Operation
- Reset values: all outputs 0; state RUN; counter 0; settle counter 0; watchdog 0.
- In-flight counter update, every cycle and in every state:
  - next = count + i_Issue − i_Retire − (i_Squash ? i_Squash_Count : 0).
  - Computed at COUNT_BITS+2 signed width.
  - Result below 0 clamps to 0; result above max saturates at max.
- State RUN:
  - `o_Stall_Fetch` = 0, `o_Pipeline_Flushed` = 0.
  - `i_Halt_Request` = 1 → DRAIN.
- State DRAIN:
  - `o_Stall_Fetch` = 1.
  - Settle counter increments on each cycle with (next count == 0 && !i_Mem_Busy) and resets to 0 otherwise.
  - Settle counter reaching SETTLE_CYCLES → HALTED.
  - `i_Halt_Request` = 0 → RUN (abort). Settle counter cleared.
- State HALTED:
  - `o_Stall_Fetch` = 1, `o_Pipeline_Flushed` = 1.
  - `i_Halt_Request` = 0 → RUN.
  - A rising edge of `i_Write_PC_Enable` (registered previous value 0, current 1) gives `o_PC_Load` = 1 for exactly one cycle, with `o_PC_Load_Data` = `i_Write_PC_Data` captured on the same edge.
- PC-write edges outside HALTED are ignored and never replayed later. The edge detector still updates in every state.
- `o_PC_Load_Data` holds its last value between loads.
- `i_Issue` is counted even when `o_Stall_Fetch` = 1. This covers the instruction already issued in the cycle the stall took effect.
- A squash and a retire in the same cycle both apply.

## Timing
- All outputs are registered.
- `o_Stall_Fetch` rises 1 cycle after `i_Halt_Request` is first sampled high.
- With an empty pipeline and idle memory, `o_Pipeline_Flushed` rises SETTLE_CYCLES+1 cycles after the request is sampled.
- Unhalt: `o_Stall_Fetch` and `o_Pipeline_Flushed` fall 1 cycle after `i_Halt_Request` is sampled low.
- `o_PC_Load` rises 1 cycle after the enable edge is sampled.
- Halt deasserted in the same cycle as the PC-write edge: the load is still issued, because HALTED is evaluated before the exit transition.
- Synchronous `i_Reset` mid-drain or mid-load: next cycle all outputs are 0 and the state is RUN. A pending load is dropped.

## Configuration
- `DEBUG_HALT_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in DRAIN.
  - Reaching TIMEOUT_CYCLES forces HALTED and sets `o_Drain_Timeout` = 1.
  - The flag is sticky until `i_Reset`.
  - The watchdog clears on every DRAIN entry.
- `DEBUG_HALT_TIMEOUT_EN` undefined:
  - No watchdog logic.
  - DRAIN waits indefinitely.
  - `o_Drain_Timeout` tied to 0.

## Test plan
- Reset, counter 0, memory idle, halt raised at cycle 0 → `o_Stall_Fetch` = 1 at cycle 1, `o_Pipeline_Flushed` = 1 at cycle 3 (SETTLE_CYCLES = 2).
- Issue 3 instructions, then halt; retire one per cycle from cycle 2 → flushed exactly 2 cycles after the third retire.
- During DRAIN with count 3: squash with `i_Squash_Count` = 2 plus a simultaneous retire → count 0. A squash of 3 at count 1 → count clamps to 0, no wrap.
- HALTED: raise `i_Write_PC_Enable` with data 0x0000_1000 and hold it 5 cycles → a single `o_PC_Load` pulse, data 0x0000_1000. The same edge while in RUN → no pulse.
- Halt dropped mid-DRAIN → RUN, stall 0 next cycle, flushed never asserted. `i_Reset` asserted in HALTED → all outputs 0 next cycle.
- With `DEBUG_HALT_TIMEOUT_EN` and TIMEOUT_CYCLES = 16, `i_Mem_Busy` held 1 → HALTED and `o_Drain_Timeout` = 1 after 16 DRAIN cycles; the flag persists through unhalt.

Source files
------------

// File: rtl/debug_halt_controller.sv
// Debug halt controller: turns a debug halt request into a fetch stall, tracks in-flight work,
// reports a flushed pipeline and issues PC load strobes while halted. Define DEBUG_HALT_TIMEOUT_EN for a drain watchdog.
module debug_halt_controller #(
    parameter int COUNT_BITS     = 3,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Halt_Request,
    input  logic        i_Issue,
    input  logic        i_Retire,
    input  logic        i_Squash,
    input  logic [1:0]  i_Squash_Count,
    input  logic        i_Mem_Busy,
    input  logic        i_Write_PC_Enable,
    input  logic [31:0] i_Write_PC_Data,
    output logic        o_Stall_Fetch,
    output logic        o_Pipeline_Flushed,
    output logic        o_PC_Load,
    output logic [31:0] o_PC_Load_Data,
    output logic        o_Drain_Timeout
);
    localparam int CW = COUNT_BITS + 2;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_TARGET = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t                state_r;
    logic [COUNT_BITS-1:0] count_r;
    logic [COUNT_BITS-1:0] next_count_s;
    logic [CW-1:0]         sum_s;
    logic [SW-1:0]         settle_r;
    logic [SW-1:0]         settle_inc_s;
    logic                  wpc_prev_r;
    logic                  wpc_edge_s;
    logic                  quiet_s;

`ifdef DEBUG_HALT_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] TIMEOUT_TARGET = WD_BITS'(TIMEOUT_CYCLES);
    logic [WD_BITS-1:0] wd_r;
    logic [WD_BITS-1:0] wd_inc_s;
    logic               timeout_r;

    // Watchdog increment
    always_comb begin
        wd_inc_s = wd_r + WD_BITS'(1'b1);
    end

    assign o_Drain_Timeout = timeout_r;
`else
    // The watchdog limit has no effect in this build
    localparam bit TIMEOUT_IGNORED = (TIMEOUT_CYCLES != 32'sd0);
    assign o_Drain_Timeout = TIMEOUT_IGNORED & 1'b0;
`endif

    // Next in-flight count (sign bit clamps at 0, bit COUNT_BITS saturates), quiet and PC-write edge detection
    always_comb begin
        sum_s = {2'b00, count_r}
              + {{(CW-1){1'b0}}, i_Issue}
              - {{(CW-1){1'b0}}, i_Retire}
              - (i_Squash ? {{(CW-2){1'b0}}, i_Squash_Count} : {CW{1'b0}});
        if (sum_s[CW-1]) begin
            next_count_s = {COUNT_BITS{1'b0}};
        end else if (sum_s[COUNT_BITS]) begin
            next_count_s = {COUNT_BITS{1'b1}};
        end else begin
            next_count_s = sum_s[COUNT_BITS-1:0];
        end
        quiet_s      = (next_count_s == {COUNT_BITS{1'b0}}) && !i_Mem_Busy;
        settle_inc_s = settle_r + SW'(1'b1);
        wpc_edge_s   = i_Write_PC_Enable && !wpc_prev_r;
    end

    // In-flight counter and PC-write edge history, updated in every state
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count_r    <= {COUNT_BITS{1'b0}};
            wpc_prev_r <= 1'b0;
        end else begin
            count_r    <= next_count_s;
            wpc_prev_r <= i_Write_PC_Enable;
        end
    end

    // Halt FSM with registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r            <= ST_RUN;
            settle_r           <= {SW{1'b0}};
            o_Stall_Fetch      <= 1'b0;
            o_Pipeline_Flushed <= 1'b0;
            o_PC_Load          <= 1'b0;
            o_PC_Load_Data     <= 32'h0000_0000;
`ifdef DEBUG_HALT_TIMEOUT_EN
            wd_r               <= {WD_BITS{1'b0}};
            timeout_r          <= 1'b0;
`endif
        end else begin
            o_PC_Load <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    settle_r           <= {SW{1'b0}};
                    o_Pipeline_Flushed <= 1'b0;
                    if (i_Halt_Request) begin
                        state_r       <= ST_DRAIN;
                        o_Stall_Fetch <= 1'b1;
`ifdef DEBUG_HALT_TIMEOUT_EN
                        wd_r          <= {WD_BITS{1'b0}};
`endif
                    end else begin
                        o_Stall_Fetch <= 1'b0;
                    end
                end
                ST_DRAIN: begin
`ifdef DEBUG_HALT_TIMEOUT_EN
                    wd_r <= wd_inc_s;
`endif
                    if (!i_Halt_Request) begin
                        state_r            <= ST_RUN;
                        settle_r           <= {SW{1'b0}};
                        o_Stall_Fetch      <= 1'b0;
                        o_Pipeline_Flushed <= 1'b0;
                    end else if (quiet_s && (settle_inc_s == SETTLE_TARGET)) begin
                        state_r            <= ST_HALTED;
                        settle_r           <= {SW{1'b0}};
                        o_Stall_Fetch      <= 1'b1;
                        o_Pipeline_Flushed <= 1'b1;
`ifdef DEBUG_HALT_TIMEOUT_EN
                    end else if (wd_inc_s == TIMEOUT_TARGET) begin
                        state_r            <= ST_HALTED;
                        settle_r           <= {SW{1'b0}};
                        timeout_r          <= 1'b1;
                        o_Stall_Fetch      <= 1'b1;
                        o_Pipeline_Flushed <= 1'b1;
`endif
                    end else begin
                        settle_r           <= quiet_s ? settle_inc_s : {SW{1'b0}};
                        o_Stall_Fetch      <= 1'b1;
                        o_Pipeline_Flushed <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    settle_r <= {SW{1'b0}};
                    // The load is evaluated before the exit so a same-cycle unhalt still delivers it
                    if (wpc_edge_s) begin
                        o_PC_Load      <= 1'b1;
                        o_PC_Load_Data <= i_Write_PC_Data;
                    end
                    if (!i_Halt_Request) begin
                        state_r            <= ST_RUN;
                        o_Stall_Fetch      <= 1'b0;
                        o_Pipeline_Flushed <= 1'b0;
                    end else begin
                        o_Stall_Fetch      <= 1'b1;
                        o_Pipeline_Flushed <= 1'b1;
                    end
                end
                default: begin
                    state_r            <= ST_RUN;
                    settle_r           <= {SW{1'b0}};
                    o_Stall_Fetch      <= 1'b0;
                    o_Pipeline_Flushed <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_halt_controller.sv
// Self-checking bench for debug_halt_controller: directed scenarios plus a randomized run against a behavioural model.
module tb_debug_halt_controller;
    localparam int COUNT_BITS = 3;
    localparam int SETTLE     = 2;
    localparam int TIMEOUT    = 16;
`ifdef DEBUG_HALT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int P_RUN = 0, P_DRAIN = 1, P_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0, issue = 1'b0, retire = 1'b0, squash = 1'b0;
    logic [1:0]  sq_cnt = 2'd0;
    logic        busy = 1'b0, wpc = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        stall, flushed, load, tout;
    logic [31:0] ldata;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int          m_count = 0, m_phase = P_RUN, m_quiet = 0, m_drain = 0;
    bit          m_prev = 1'b0, m_tout = 1'b0;
    bit          e_stall = 1'b0, e_flushed = 1'b0, e_load = 1'b0;
    logic [31:0] e_data = 32'h0;

    debug_halt_controller #(
        .COUNT_BITS(COUNT_BITS), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Halt_Request(halt), .i_Issue(issue),
        .i_Retire(retire), .i_Squash(squash), .i_Squash_Count(sq_cnt), .i_Mem_Busy(busy),
        .i_Write_PC_Enable(wpc), .i_Write_PC_Data(wdata),
        .o_Stall_Fetch(stall), .o_Pipeline_Flushed(flushed), .o_PC_Load(load),
        .o_PC_Load_Data(ldata), .o_Drain_Timeout(tout)
    );

    always #5 clk = ~clk;

    function automatic void model_update();
        int nxt;
        if (rst) begin
            m_count = 0; m_phase = P_RUN; m_quiet = 0; m_drain = 0; m_prev = 1'b0; m_tout = 1'b0;
            e_stall = 1'b0; e_flushed = 1'b0; e_load = 1'b0; e_data = 32'h0;
            return;
        end
        nxt = m_count + int'(issue) - int'(retire) - (squash ? int'(sq_cnt) : 0);
        if (nxt < 0) nxt = 0;
        else if (nxt > (1 << COUNT_BITS) - 1) nxt = (1 << COUNT_BITS) - 1;
        e_load = 1'b0;
        case (m_phase)
            P_RUN: if (halt) begin m_phase = P_DRAIN; m_quiet = 0; m_drain = 0; end
            P_DRAIN: begin
                m_drain++;
                if (!halt) begin
                    m_phase = P_RUN; m_quiet = 0;
                end else begin
                    m_quiet = (nxt == 0 && !busy) ? m_quiet + 1 : 0;
                    if (m_quiet >= SETTLE) begin
                        m_phase = P_HALT; m_quiet = 0;
                    end else if (TO_EN && m_drain >= TIMEOUT) begin
                        m_phase = P_HALT; m_quiet = 0; m_tout = 1'b1;
                    end
                end
            end
            default: begin
                if (wpc && !m_prev) begin e_load = 1'b1; e_data = wdata; end
                if (!halt) m_phase = P_RUN;
            end
        endcase
        m_prev    = wpc;
        m_count   = nxt;
        e_stall   = (m_phase != P_RUN);
        e_flushed = (m_phase == P_HALT);
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        halt = 1'b0; issue = 1'b0; retire = 1'b0; squash = 1'b0; sq_cnt = 2'd0;
        busy = 1'b0; wpc = 1'b0; wdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (flushed !== 1'b0)     begin errors++; $display("FAIL reset_flushed: got %b want 0", flushed); end
        checks++; if (load !== 1'b0)        begin errors++; $display("FAIL reset_load: got %b want 0", load); end
        checks++; if (ldata !== 32'h0)      begin errors++; $display("FAIL reset_data: got %h want 0", ldata); end
        checks++; if (tout !== 1'b0)        begin errors++; $display("FAIL reset_timeout: got %b want 0", tout); end
    endtask

    task automatic test_halt_empty();
        do_reset();
        halt = 1'b1;
        step();
        checks++; if (stall !== 1'b1)   begin errors++; $display("FAIL halt_stall_c1: got %b want 1", stall); end
        checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL halt_flushed_c1: got %b want 0", flushed); end
        step();
        checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL halt_flushed_c2: got %b want 0", flushed); end
        step();
        checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL halt_flushed_c3: got %b want 1", flushed); end
        halt = 1'b0;
        step();
        checks++; if (stall !== 1'b0 || flushed !== 1'b0)
            begin errors++; $display("FAIL unhalt: got stall=%b flushed=%b want 0 0", stall, flushed); end
    endtask

    task automatic test_drain_retire();
        do_reset();
        issue = 1'b1;
        repeat (3) step();
        issue = 1'b0; halt = 1'b1;
        step();
        retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL drain_retire_%0d: got %b want 0", i, flushed); end
        end
        retire = 1'b0;
        step();
        checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL drain_flushed: got %b want 1", flushed); end
    endtask

    task automatic test_squash();
        do_reset();
        issue = 1'b1;
        repeat (3) step();
        issue = 1'b0; halt = 1'b1; busy = 1'b1;
        step();
        squash = 1'b1; sq_cnt = 2'd2; retire = 1'b1; busy = 1'b0;
        step();
        checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL squash_retire_c0: got %b want 0", flushed); end
        squash = 1'b0; retire = 1'b0;
        step();
        checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL squash_retire_c1: got %b want 1", flushed); end
        halt = 1'b0;
        step();
        issue = 1'b1;
        step();
        issue = 1'b0; halt = 1'b1; busy = 1'b1;
        step();
        squash = 1'b1; sq_cnt = 2'd3; busy = 1'b0;
        step();
        checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL squash_clamp_c0: got %b want 0", flushed); end
        squash = 1'b0;
        step();
        checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL squash_clamp_c1: got %b want 1", flushed); end
    endtask

    task automatic test_pc_load();
        do_reset();
        halt = 1'b1;
        repeat (3) step();
        wpc = 1'b1; wdata = 32'h0000_1000;
        step();
        checks++; if (load !== 1'b1 || ldata !== 32'h0000_1000)
            begin errors++; $display("FAIL pc_load_pulse: got load=%b data=%h want 1 00001000", load, ldata); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (load !== 1'b0 || ldata !== 32'h0000_1000)
                begin errors++; $display("FAIL pc_load_hold_%0d: got load=%b data=%h want 0 00001000", i, load, ldata); end
        end
        wpc = 1'b0; step();
        halt = 1'b0; step();
        wpc = 1'b1; wdata = 32'h0000_2000;
        step();
        checks++; if (load !== 1'b0 || ldata !== 32'h0000_1000)
            begin errors++; $display("FAIL pc_load_run: got load=%b data=%h want 0 00001000", load, ldata); end
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (load !== 1'b0) begin errors++; $display("FAIL pc_no_replay_%0d: got %b want 0", i, load); end
        end
        wpc = 1'b0; step();
        wpc = 1'b1; wdata = 32'h0000_3000; halt = 1'b0;
        step();
        checks++; if (load !== 1'b1 || ldata !== 32'h0000_3000 || stall !== 1'b0)
            begin errors++; $display("FAIL pc_load_exit: got load=%b data=%h stall=%b want 1 00003000 0", load, ldata, stall); end
        wpc = 1'b0; step();
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL pc_load_end: got %b want 0", load); end
    endtask

    task automatic test_abort_and_reset();
        do_reset();
        halt = 1'b1; busy = 1'b1;
        repeat (2) step();
        halt = 1'b0;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b want 0", stall); end
        busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL abort_flushed_%0d: got %b want 0", i, flushed); end
        end
        halt = 1'b1;
        repeat (3) step();
        wpc = 1'b1; wdata = 32'h0000_abcd; rst = 1'b1;
        step();
        checks++; if (stall !== 1'b0 || flushed !== 1'b0 || load !== 1'b0 || ldata !== 32'h0)
            begin errors++; $display("FAIL reset_halted: got %b %b %b %h want 0 0 0 0", stall, flushed, load, ldata); end
        rst = 1'b0; clear_inputs();
        step();
    endtask

`ifdef DEBUG_HALT_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        halt = 1'b1; busy = 1'b1;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            checks++; if (flushed !== 1'b0 || tout !== 1'b0)
                begin errors++; $display("FAIL timeout_early_%0d: got %b %b want 0 0", i, flushed, tout); end
        end
        step();
        checks++; if (flushed !== 1'b1 || tout !== 1'b1)
            begin errors++; $display("FAIL timeout_hit: got %b %b want 1 1", flushed, tout); end
        halt = 1'b0;
        step();
        checks++; if (stall !== 1'b0 || tout !== 1'b1)
            begin errors++; $display("FAIL timeout_sticky: got stall=%b flag=%b want 0 1", stall, tout); end
        busy = 1'b0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) halt = ~halt;
            issue  = halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            retire = 1'($urandom_range(0, 1));
            squash = ($urandom_range(0, 9) == 0);
            sq_cnt = 2'($urandom_range(0, 3));
            busy   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) wpc = ~wpc;
            wdata  = $urandom;
            step();
            checks++; if (stall !== e_stall)     begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", i, stall, e_stall); end
            checks++; if (flushed !== e_flushed) begin errors++; $display("FAIL rnd_flushed @%0d: got %b want %b", i, flushed, e_flushed); end
            checks++; if (load !== e_load)       begin errors++; $display("FAIL rnd_load @%0d: got %b want %b", i, load, e_load); end
            checks++; if (ldata !== e_data)      begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", i, ldata, e_data); end
            checks++; if (tout !== m_tout)       begin errors++; $display("FAIL rnd_timeout @%0d: got %b want %b", i, tout, m_tout); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halt_empty();
        test_drain_retire();
        test_squash();
        test_pc_load();
        test_abort_and_reset();
`ifdef DEBUG_HALT_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
